// File: rtl/riscv_rf_pkg.sv
// -----------------------------------------------------------------------------
// riscv_rf_pkg
// Shared types and constants for the register-file write-back path.
//   RF_WB_MAX_REQ  : upper bound on the number of write-back producers
//   RF_ADDR_WIDTH  : default register address width (bit 5 = FP bank)
//   RF_DATA_WIDTH  : default write data width
//   rf_wb_req_t    : one write-back request {addr, data, tag} at default widths
// -----------------------------------------------------------------------------
package riscv_rf_pkg;

  localparam int RF_WB_MAX_REQ = 8;
  localparam int RF_ADDR_WIDTH = 6;
  localparam int RF_DATA_WIDTH = 32;

  typedef struct packed {
    logic [RF_ADDR_WIDTH-1:0] addr;
    logic [RF_DATA_WIDTH-1:0] data;
    logic                     tag;
  } rf_wb_req_t;

endpackage : riscv_rf_pkg

// File: rtl/riscv_rf_wb_arbiter_pick2.sv
// -----------------------------------------------------------------------------
// riscv_rr_pick2
// Round-robin dual picker. Scans the eligible mask starting at rr_ptr_i and
// wrapping modulo NUM_REQ. The first eligible requester gets grant A; the next
// eligible requester whose address differs from A's gets grant B. Anything
// else (including a second request to A's address) is left ungranted.
// Ports:
//   elig_i     in  NUM_REQ              eligible requesters (valid, addr != 0)
//   rr_ptr_i   in  PTR_W                scan start position
//   addr_i     in  NUM_REQ*ADDR_WIDTH   destination addresses, packed
//   grant_a_o  out NUM_REQ              one-hot (or zero) grant for port A
//   grant_b_o  out NUM_REQ              one-hot (or zero) grant for port B
// -----------------------------------------------------------------------------
module riscv_rr_pick2 #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 6,
  parameter int PTR_W      = 2
) (
  input  logic [NUM_REQ-1:0]            elig_i,
  input  logic [PTR_W-1:0]              rr_ptr_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i,
  output logic [NUM_REQ-1:0]            grant_a_o,
  output logic [NUM_REQ-1:0]            grant_b_o
);

  always_comb begin : pick
    int                    pos;
    logic                  found_a;
    logic                  found_b;
    logic [ADDR_WIDTH-1:0] addr_a;
    grant_a_o = '0;
    grant_b_o = '0;
    found_a   = 1'b0;
    found_b   = 1'b0;
    addr_a    = '0;
    pos       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = int'(rr_ptr_i) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      // Inner loop keeps every select at a constant index; exactly one i matches.
      for (int i = 0; i < NUM_REQ; i++) begin
        if (i == pos && elig_i[i]) begin
          if (!found_a) begin
            grant_a_o[i] = 1'b1;
            found_a      = 1'b1;
            addr_a       = addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
          end else if (!found_b && (addr_i[i*ADDR_WIDTH +: ADDR_WIDTH] != addr_a)) begin
            grant_b_o[i] = 1'b1;
            found_b      = 1'b1;
          end
        end
      end
    end
  end

endmodule : riscv_rr_pick2

// File: rtl/riscv_rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// riscv_rf_wb_arbiter
// Write-back arbiter for the register file's two write ports (W1 = A, W2 = B).
// Handshake: a transfer happens when req_valid_i[i] and req_ready_o[i] are both
// high at posedge clk; valid never depends on ready, and a requester holds
// valid/addr/data/tag stable until accepted. req_ready_o is combinational.
// Requests to integer x0 (addr == 0) are always ready and never use a port.
// Up to two requests per cycle are granted in round-robin order; the port
// registers present the granted write one cycle after acceptance.
// Optional feature macro: RF_WB_ARB_STATS_EN builds the saturating stall
// counter; without it stall_cnt_o is tied to 0.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   req_valid_i/ready_o  NUM_REQ     per-requester handshake
//   req_addr_i  NUM_REQ*ADDR_WIDTH   destination registers, packed
//   req_data_i  NUM_REQ*DATA_WIDTH   write data, packed
//   req_tag_i   NUM_REQ              tag bit
//   waddr/wdata/wtag/we _a_o         register-file port W1
//   waddr/wdata/wtag/we _b_o         register-file port W2
//   stall_cnt_o 32                   eligible-but-not-ready request-cycles
// -----------------------------------------------------------------------------
module riscv_rf_wb_arbiter
  import riscv_rf_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]            req_tag_i,
  output logic [ADDR_WIDTH-1:0]         waddr_a_o,
  output logic [DATA_WIDTH-1:0]         wdata_a_o,
  output logic                          wtag_a_o,
  output logic                          we_a_o,
  output logic [ADDR_WIDTH-1:0]         waddr_b_o,
  output logic [DATA_WIDTH-1:0]         wdata_b_o,
  output logic                          wtag_b_o,
  output logic                          we_b_o,
  output logic [31:0]                   stall_cnt_o
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    addr_zero;
  logic [NUM_REQ-1:0]    elig;
  logic [NUM_REQ-1:0]    grant_a;
  logic [NUM_REQ-1:0]    grant_b;
  logic [PTR_W-1:0]      last_idx;

  logic [PTR_W-1:0]      rr_ptr_q,  rr_ptr_d;
  logic                  we_a_q,    we_a_d;
  logic [ADDR_WIDTH-1:0] waddr_a_q, waddr_a_d;
  logic [DATA_WIDTH-1:0] wdata_a_q, wdata_a_d;
  logic                  wtag_a_q,  wtag_a_d;
  logic                  we_b_q,    we_b_d;
  logic [ADDR_WIDTH-1:0] waddr_b_q, waddr_b_d;
  logic [DATA_WIDTH-1:0] wdata_b_q, wdata_b_d;
  logic                  wtag_b_q,  wtag_b_d;

  always_comb begin : decode
    addr_zero = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_zero[i] = (req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH] == '0);
    end
  end

  assign elig = req_valid_i & ~addr_zero;

  riscv_rr_pick2 #(
    .NUM_REQ    (NUM_REQ),
    .ADDR_WIDTH (ADDR_WIDTH),
    .PTR_W      (PTR_W)
  ) u_pick2 (
    .elig_i    (elig),
    .rr_ptr_i  (rr_ptr_q),
    .addr_i    (req_addr_i),
    .grant_a_o (grant_a),
    .grant_b_o (grant_b)
  );

  // x0 writes are absorbed unconditionally; everything else needs a port.
  assign req_ready_o = addr_zero | grant_a | grant_b;

  always_comb begin : next_state
    rr_ptr_d  = rr_ptr_q;
    last_idx  = '0;
    we_a_d    = |grant_a;
    waddr_a_d = waddr_a_q;
    wdata_a_d = wdata_a_q;
    wtag_a_d  = wtag_a_q;
    we_b_d    = |grant_b;
    waddr_b_d = waddr_b_q;
    wdata_b_d = wdata_b_q;
    wtag_b_d  = wtag_b_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_a[i]) begin
        waddr_a_d = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        wdata_a_d = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
        wtag_a_d  = req_tag_i[i];
        last_idx  = PTR_W'(i);
      end
    end
    // B is always later in scan order than A, so it overrides last_idx.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_b[i]) begin
        waddr_b_d = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        wdata_b_d = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
        wtag_b_d  = req_tag_i[i];
        last_idx  = PTR_W'(i);
      end
    end
    if (|grant_a) begin
      rr_ptr_d = (last_idx == PTR_W'(NUM_REQ - 1)) ? '0 : last_idx + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q  <= '0;
      we_a_q    <= 1'b0;
      waddr_a_q <= '0;
      wdata_a_q <= '0;
      wtag_a_q  <= 1'b0;
      we_b_q    <= 1'b0;
      waddr_b_q <= '0;
      wdata_b_q <= '0;
      wtag_b_q  <= 1'b0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      we_a_q    <= we_a_d;
      waddr_a_q <= waddr_a_d;
      wdata_a_q <= wdata_a_d;
      wtag_a_q  <= wtag_a_d;
      we_b_q    <= we_b_d;
      waddr_b_q <= waddr_b_d;
      wdata_b_q <= wdata_b_d;
      wtag_b_q  <= wtag_b_d;
    end
  end

  assign we_a_o    = we_a_q;
  assign waddr_a_o = waddr_a_q;
  assign wdata_a_o = wdata_a_q;
  assign wtag_a_o  = wtag_a_q;
  assign we_b_o    = we_b_q;
  assign waddr_b_o = waddr_b_q;
  assign wdata_b_o = wdata_b_q;
  assign wtag_b_o  = wtag_b_q;

`ifdef RF_WB_ARB_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [32:0] stall_sum;

  // Eligible requests always carry a nonzero address, so "not ready" for
  // them is exactly "not granted". One extra bit catches the wrap.
  always_comb begin : stall_next
    stall_sum = {1'b0, stall_cnt_q};
    for (int i = 0; i < NUM_REQ; i++) begin
      if (elig[i] && !grant_a[i] && !grant_b[i]) stall_sum = stall_sum + 33'd1;
    end
    stall_cnt_d = stall_sum[32] ? 32'hFFFF_FFFF : stall_sum[31:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule : riscv_rf_wb_arbiter

// File: tb/tb_riscv_rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_riscv_rf_wb_arbiter
// Bench for riscv_rf_wb_arbiter (NUM_REQ = 4). Requesters are kept as a list of
// pending records; a reference model picks grants from the eligible list in
// round-robin order and predicts the registered port values one cycle later.
// -----------------------------------------------------------------------------
module tb_riscv_rf_wb_arbiter;
  import riscv_rf_pkg::*;

  localparam int NR = 4;
  localparam int AW = 6;
  localparam int DW = 32;
`ifdef RF_WB_ARB_STATS_EN
  localparam logic [31:0] EXP_STALL_ONE = 32'd1;
`else
  localparam logic [31:0] EXP_STALL_ONE = 32'd0;
`endif

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [NR-1:0]    req_valid_i;
  logic [NR-1:0]    req_ready_o;
  logic [NR*AW-1:0] req_addr_i;
  logic [NR*DW-1:0] req_data_i;
  logic [NR-1:0]    req_tag_i;
  logic [AW-1:0]    waddr_a_o, waddr_b_o;
  logic [DW-1:0]    wdata_a_o, wdata_b_o;
  logic             wtag_a_o, wtag_b_o, we_a_o, we_b_o;
  logic [31:0]      stall_cnt_o;

  riscv_rf_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr_i),
    .req_data_i  (req_data_i),
    .req_tag_i   (req_tag_i),
    .waddr_a_o   (waddr_a_o),
    .wdata_a_o   (wdata_a_o),
    .wtag_a_o    (wtag_a_o),
    .we_a_o      (we_a_o),
    .waddr_b_o   (waddr_b_o),
    .wdata_b_o   (wdata_b_o),
    .wtag_b_o    (wtag_b_o),
    .we_b_o      (we_b_o),
    .stall_cnt_o (stall_cnt_o)
  );

  // ---------------- bookkeeping ----------------
  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Pending request per requester (held until accepted).
  logic       v  [NR];
  rf_wb_req_t rq [NR];

  // Scoreboard: writes in grant order, {addr, data, tag}.
  logic [AW+DW:0] exp_q [$];

  // Reference model state.
  int          m_ptr;
  logic        m_we_a, m_we_b;
  logic [AW-1:0] m_addr_a, m_addr_b;
  logic [DW-1:0] m_data_a, m_data_b;
  logic        m_tag_a, m_tag_b;
  logic [31:0] m_stall;
  logic [NR-1:0] last_ready;

  task automatic model_reset();
    m_ptr = 0;
    m_we_a = 1'b0; m_we_b = 1'b0;
    m_addr_a = '0; m_addr_b = '0;
    m_data_a = '0; m_data_b = '0;
    m_tag_a = 1'b0; m_tag_b = 1'b0;
    m_stall = '0;
    exp_q.delete();
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NR; i++) begin
      v[i]  = 1'b0;
      rq[i] = '0;
    end
    req_valid_i = '0;
  endtask

  // ---------------- driver + model + per-cycle checks ----------------
  // Called just after a posedge; ends just after the next posedge.
  task automatic step();
    int order_elig[$];
    int ga, gb, nstall, j;
    logic [NR-1:0] exp_rdy;
    for (int i = 0; i < NR; i++) begin
      req_valid_i[i]           = v[i];
      req_addr_i[i*AW +: AW]   = rq[i].addr;
      req_data_i[i*DW +: DW]   = rq[i].data;
      req_tag_i[i]             = rq[i].tag;
    end
    #1;
    // Eligible list in scan order from the pointer.
    for (int k = 0; k < NR; k++) begin
      j = (m_ptr + k) % NR;
      if (v[j] && rq[j].addr != '0) order_elig.push_back(j);
    end
    ga = -1; gb = -1;
    if (order_elig.size() > 0) ga = order_elig[0];
    for (int k = 1; k < order_elig.size(); k++) begin
      if (gb < 0 && rq[order_elig[k]].addr != rq[ga].addr) gb = order_elig[k];
    end
    for (int i = 0; i < NR; i++) exp_rdy[i] = v[i] && (rq[i].addr == '0 || i == ga || i == gb);
    chk_cnt++;
    if ((req_ready_o & req_valid_i) !== exp_rdy)
      $display("FAIL ready: got %b want %b (valid %b ptr %0d)", req_ready_o & req_valid_i, exp_rdy, req_valid_i, m_ptr);
    else pass_cnt++;
    last_ready = req_ready_o & req_valid_i;
    nstall = order_elig.size() - ((ga >= 0) ? 1 : 0) - ((gb >= 0) ? 1 : 0);
    if (ga >= 0) exp_q.push_back({rq[ga].addr, rq[ga].data, rq[ga].tag});
    if (gb >= 0) exp_q.push_back({rq[gb].addr, rq[gb].data, rq[gb].tag});

    @(posedge clk); #1;

    m_we_a = (ga >= 0);
    m_we_b = (gb >= 0);
    if (ga >= 0) {m_addr_a, m_data_a, m_tag_a} = exp_q.pop_front();
    if (gb >= 0) {m_addr_b, m_data_b, m_tag_b} = exp_q.pop_front();
    if (ga >= 0) m_ptr = (((gb >= 0) ? gb : ga) + 1) % NR;
`ifdef RF_WB_ARB_STATS_EN
    if ({1'b0, m_stall} + 33'(nstall) > 33'h0_FFFF_FFFF) m_stall = 32'hFFFF_FFFF;
    else m_stall = m_stall + 32'(nstall);
`endif
    for (int i = 0; i < NR; i++) if (exp_rdy[i]) v[i] = 1'b0;

    chk_cnt++;
    if ({we_a_o, waddr_a_o, wdata_a_o, wtag_a_o} !== {m_we_a, m_addr_a, m_data_a, m_tag_a})
      $display("FAIL port_a: got we=%b a=%0d d=%h t=%b want we=%b a=%0d d=%h t=%b",
               we_a_o, waddr_a_o, wdata_a_o, wtag_a_o, m_we_a, m_addr_a, m_data_a, m_tag_a);
    else pass_cnt++;
    chk_cnt++;
    if ({we_b_o, waddr_b_o, wdata_b_o, wtag_b_o} !== {m_we_b, m_addr_b, m_data_b, m_tag_b})
      $display("FAIL port_b: got we=%b a=%0d d=%h t=%b want we=%b a=%0d d=%h t=%b",
               we_b_o, waddr_b_o, wdata_b_o, wtag_b_o, m_we_b, m_addr_b, m_data_b, m_tag_b);
    else pass_cnt++;
    chk_cnt++;
    if (dut.rr_ptr_q !== 2'(m_ptr))
      $display("FAIL rr_ptr: got %0d want %0d", dut.rr_ptr_q, m_ptr);
    else pass_cnt++;
    chk_cnt++;
    if (stall_cnt_o !== m_stall)
      $display("FAIL stall_cnt: got %0d want %0d", stall_cnt_o, m_stall);
    else pass_cnt++;
    chk_cnt++;
    if (we_a_o && we_b_o && waddr_a_o == waddr_b_o)
      $display("FAIL same_addr_ports: got both ports at addr %0d want distinct", waddr_a_o);
    else pass_cnt++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_reqs();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1 rst_n = 1'b0;
    #10;
    chk_cnt++;
    if ({we_a_o, we_b_o, waddr_a_o, waddr_b_o, wdata_a_o, wdata_b_o, wtag_a_o, wtag_b_o, stall_cnt_o} !== '0)
      $display("FAIL reset_outputs: got we=%b%b a=%0d/%0d stall=%0d want all zero",
               we_a_o, we_b_o, waddr_a_o, waddr_b_o, stall_cnt_o);
    else pass_cnt++;
    chk_cnt++;
    if (dut.rr_ptr_q !== 2'd0) $display("FAIL reset_ptr: got %0d want 0", dut.rr_ptr_q);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    v[1]  = 1'b1;
    rq[1] = '{addr: 6'd5, data: 32'hDEAD_BEEF, tag: 1'b0};
    step();
    chk_cnt++;
    if (last_ready !== 4'b0010) $display("FAIL single_ready: got %b want 0010", last_ready);
    else pass_cnt++;
    chk_cnt++;
    if ({we_a_o, waddr_a_o, wdata_a_o, we_b_o} !== {1'b1, 6'd5, 32'hDEAD_BEEF, 1'b0})
      $display("FAIL single_write: got we_a=%b a=%0d d=%h we_b=%b want 1/5/deadbeef/0",
               we_a_o, waddr_a_o, wdata_a_o, we_b_o);
    else pass_cnt++;
    step();  // idle cycle: we must drop, values hold
  endtask

  task automatic test_all_four();
    do_reset();
    for (int i = 0; i < NR; i++) begin
      v[i]  = 1'b1;
      rq[i] = '{addr: AW'(i + 1), data: $urandom, tag: 1'($urandom_range(0, 1))};
    end
    step();
    chk_cnt++;
    if (last_ready !== 4'b0011) $display("FAIL all4_cycle0: got %b want 0011", last_ready);
    else pass_cnt++;
    step();
    chk_cnt++;
    if (last_ready !== 4'b1100) $display("FAIL all4_cycle1: got %b want 1100", last_ready);
    else pass_cnt++;
    chk_cnt++;
    if (dut.rr_ptr_q !== 2'd0) $display("FAIL all4_ptr: got %0d want 0", dut.rr_ptr_q);
    else pass_cnt++;
  endtask

  task automatic test_same_addr();
    v[0] = 1'b1; rq[0] = '{addr: 6'd7, data: 32'h1111_0000, tag: 1'b1};
    v[2] = 1'b1; rq[2] = '{addr: 6'd7, data: 32'h2222_0000, tag: 1'b0};
    step();
    chk_cnt++;
    if (last_ready !== 4'b0001 || we_b_o !== 1'b0)
      $display("FAIL same_addr_first: got rdy=%b we_b=%b want 0001/0", last_ready, we_b_o);
    else pass_cnt++;
    step();
    chk_cnt++;
    if (last_ready !== 4'b0100 || wdata_a_o !== 32'h2222_0000)
      $display("FAIL same_addr_second: got rdy=%b d=%h want 0100/22220000", last_ready, wdata_a_o);
    else pass_cnt++;
  endtask

  task automatic test_x0();
    v[3] = 1'b1; rq[3] = '{addr: 6'd0, data: 32'hBAD0_BAD0, tag: 1'b0};
    v[1] = 1'b1; rq[1] = '{addr: 6'd9, data: 32'h0000_0009, tag: 1'b1};
    step();
    chk_cnt++;
    if (last_ready !== 4'b1010) $display("FAIL x0_ready: got %b want 1010", last_ready);
    else pass_cnt++;
    chk_cnt++;
    if ({we_a_o, waddr_a_o, we_b_o, dut.rr_ptr_q} !== {1'b1, 6'd9, 1'b0, 2'd2})
      $display("FAIL x0_write: got we_a=%b a=%0d we_b=%b ptr=%0d want 1/9/0/2",
               we_a_o, waddr_a_o, we_b_o, dut.rr_ptr_q);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    v[0] = 1'b1; rq[0] = '{addr: 6'd3, data: 32'hA5A5_0003, tag: 1'b0};
    v[1] = 1'b1; rq[1] = '{addr: 6'd4, data: 32'hA5A5_0004, tag: 1'b1};
    step();
    #2 rst_n = 1'b0;
    #1;
    chk_cnt++;
    if ({we_a_o, we_b_o, waddr_a_o} !== '0)
      $display("FAIL reset_mid_async: got we=%b%b a=%0d want 0", we_a_o, we_b_o, waddr_a_o);
    else pass_cnt++;
    clear_reqs();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_cnt++;
    if ({dut.rr_ptr_q, we_a_o, we_b_o} !== '0)
      $display("FAIL reset_mid_release: got ptr=%0d we=%b%b want 0", dut.rr_ptr_q, we_a_o, we_b_o);
    else pass_cnt++;
  endtask

  task automatic test_stats();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      v[i]  = 1'b1;
      rq[i] = '{addr: AW'(10 + i), data: $urandom, tag: 1'b0};
    end
    step();
    clear_reqs();
    chk_cnt++;
    if (stall_cnt_o !== EXP_STALL_ONE)
      $display("FAIL stats_one: got %0d want %0d", stall_cnt_o, EXP_STALL_ONE);
    else pass_cnt++;
    step();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!v[i] && $urandom_range(0, 99) < 60) begin
          v[i]       = 1'b1;
          rq[i].addr = AW'($urandom_range(0, 7));
          if ($urandom_range(0, 3) == 0) rq[i].addr[5] = 1'b1;
          rq[i].data = $urandom;
          rq[i].tag  = 1'($urandom_range(0, 1));
        end
      end
      step();
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1, "timeout");
  end

  // ---------------- main sequence + report ----------------
  initial begin
    req_addr_i = '0;
    req_data_i = '0;
    req_tag_i  = '0;
    clear_reqs();
    model_reset();
    last_ready = '0;
    test_reset();
    test_single();
    test_all_four();
    test_same_addr();
    test_x0();
    test_reset_mid();
    test_stats();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule : tb_riscv_rf_wb_arbiter

// File: doc/riscv_rf_wb_arbiter.md
# riscv_rf_wb_arbiter

Write-back arbiter for the latch-based register file's two write ports (W1/W2). Collects write requests from NUM_REQ producers (ALU, LSU, MULT, FPU, …) over valid/ready handshakes, grants up to two per cycle in round-robin order, and drives the port signals from registers one cycle later. Grants never place the same address on both ports in one cycle. Integer x0 writes are absorbed without using a port.

## Interface
Parameters:
- ADDR_WIDTH, 6: register address width; bit 5 selects the FP bank when the FPU is present.
- DATA_WIDTH, 32: write data width.
- NUM_REQ, 4: number of requesters, 2..8.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid_i  in  NUM_REQ  request valid per requester
- req_ready_o  out  NUM_REQ  request accepted this cycle (combinational)
- req_addr_i  in  NUM_REQ×ADDR_WIDTH  destination register
- req_data_i  in  NUM_REQ×DATA_WIDTH  write data
- req_tag_i  in  NUM_REQ  tag bit
- waddr_a_o, wdata_a_o, wtag_a_o, we_a_o  out  ADDR_WIDTH/DATA_WIDTH/1/1  register-file port W1
- waddr_b_o, wdata_b_o, wtag_b_o, we_b_o  out  ADDR_WIDTH/DATA_WIDTH/1/1  register-file port W2
- stall_cnt_o  out  32  count of stalled request-cycles (see Configuration)

## Operation
- Handshake: a transfer occurs when valid and ready are both high at the posedge. Valid must not depend on ready. Once valid is raised, the requester holds valid, address, data and tag stable until it is accepted.
- x0 absorb: a request with req_addr_i == 0 always gets ready=1. It uses no port and produces no write.
- Eligible set: valid requests with a nonzero address. Scan order starts at rr_ptr and wraps modulo NUM_REQ.
- The first eligible request takes port A.
- The next eligible request whose address differs from port A's address takes port B.
- Remaining eligible requests get ready=0, including any request that matches port A's address.
- Pointer update: if any port is granted, rr_ptr ← (index of the last port-granted requester + 1) mod NUM_REQ. Otherwise rr_ptr holds. x0 absorbs do not move rr_ptr.
- Output registers load the granted address, data and tag every cycle.
  - we_x_o = 1 only if port x was granted in the previous cycle.
  - Address, data and tag of an unused port hold their previous values.
- Ordering guarantee: writes to the same address issue in grant order. They never issue in the same cycle.

## Timing
- Latency: accept at edge N → we/addr/data valid during cycle N+1. The register file samples them at edge N+1.
- Throughput: 2 writes per cycle, plus any number of x0 absorbs.
- Reset: all outputs are 0 (we_a_o = we_b_o = 0, addr/data/tag = 0, stall_cnt_o = 0), and rr_ptr = 0.
- Reset asserted mid-operation: in-flight grants are dropped, and we_* deassert asynchronously.
- Single eligible request: it always takes port A; port B is idle.
- All NUM_REQ valid with distinct addresses: two grants per cycle. Every requester is served within ceil(NUM_REQ/2) cycles.
- Two requests to the same address: only one is granted per cycle. The other is served in the next cycle if it comes first in the scan order.

## Configuration
- RF_WB_ARB_STATS_EN defined:
  - stall_cnt_o increments by the number of eligible-but-not-ready requests each cycle.
  - It saturates at 0xFFFF_FFFF and resets to 0.
- RF_WB_ARB_STATS_EN undefined: no counter logic is built and stall_cnt_o is tied to 0.

## Structure
- Package riscv_rf_pkg holds:
  - typedef rf_wb_req_t {addr, data, tag};
  - localparam RF_WB_MAX_REQ = 8.
- Sub-module riscv_rr_pick2 takes an eligible mask, rr_ptr and the address vector. It returns the grant_a and grant_b one-hots, including the same-address exclusion.
- The top level contains the handshake, the x0 absorb logic, the pointer register, the output registers and the optional counter.

## Test plan
- Reset, then one request (r1, addr 5, data 0xDEAD_BEEF): ready in cycle 0; we_a_o=1, waddr_a_o=5, wdata_a_o=0xDEAD_BEEF in cycle 1; we_b_o=0.
- All four valid, addresses 1/2/3/4, rr_ptr=0: cycle 0 grants r0→A, r1→B; cycle 1 grants r2→A, r3→B; rr_ptr=0 again afterwards.
- r0 and r2 both valid with addr 7: only r0 is granted (port A); r2 is granted the next cycle. we_a_o and we_b_o are never both 1 with equal addresses.
- r3 valid with addr 0 and r1 valid with addr 9: both get ready the same cycle; only port A writes 9; rr_ptr becomes 2.
- Assert rst_n low while two grants are pending output: we_a_o and we_b_o go to 0 immediately; after release, rr_ptr=0.
- With RF_WB_ARB_STATS_EN, 3 distinct valid requests held for 1 cycle: stall_cnt_o = 1; without the macro, stall_cnt_o stays 0.
